// File: rtl/decode_group_nw.sv
// N-wide decode stage: per-lane decode, group truncation, compacting holding buffer
// drained by the issue queue, and single-cycle restart/call/return event pulses.

module decoder_full (
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic [79:0] o_dec,
    output logic        o_is_valid,
    output logic        o_valid_branch,
    output logic        o_is_call,
    output logic        o_is_return
);
    localparam logic [3:0] CLS_NONE   = 4'd0;
    localparam logic [3:0] CLS_ALU    = 4'd1;
    localparam logic [3:0] CLS_LOAD   = 4'd2;
    localparam logic [3:0] CLS_STORE  = 4'd3;
    localparam logic [3:0] CLS_BRANCH = 4'd4;
    localparam logic [3:0] CLS_JAL    = 4'd5;
    localparam logic [3:0] CLS_JALR   = 4'd6;
    localparam logic [3:0] CLS_SYS    = 4'd7;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [4:0] w_rd;
    logic [4:0] w_rs1;
    logic [3:0] w_cls;
    logic       w_rd_link;
    logic       w_rs1_link;

    assign w_opcode   = i_instr[6:0];
    assign w_funct3   = i_instr[14:12];
    assign w_rd       = i_instr[11:7];
    assign w_rs1      = i_instr[19:15];
    assign w_rd_link  = (w_rd == 5'd1) | (w_rd == 5'd5);
    assign w_rs1_link = (w_rs1 == 5'd1) | (w_rs1 == 5'd5);

    // Instruction class from the major opcode; anything unrecognised is illegal.
    always_comb begin
        w_cls = CLS_NONE;
        case (w_opcode)
            7'b0110111, 7'b0010111,
            7'b0010011, 7'b0110011: w_cls = CLS_ALU;
            7'b0000011:             w_cls = CLS_LOAD;
            7'b0100011:             w_cls = CLS_STORE;
            7'b1100011:             w_cls = (w_funct3[2:1] == 2'b01) ? CLS_NONE : CLS_BRANCH;
            7'b1101111:             w_cls = CLS_JAL;
            7'b1100111:             w_cls = (w_funct3 == 3'd0) ? CLS_JALR : CLS_NONE;
            7'b0001111, 7'b1110011: w_cls = CLS_SYS;
            default:                w_cls = CLS_NONE;
        endcase
    end

    // Link-register hints: x1/x5 as rd pushes the RAS, as rs1 of a non-linking JALR pops it.
    assign o_is_valid     = (w_cls != CLS_NONE);
    assign o_valid_branch = (w_cls == CLS_BRANCH) | (w_cls == CLS_JAL) | (w_cls == CLS_JALR);
    assign o_is_call      = ((w_cls == CLS_JAL) | (w_cls == CLS_JALR)) & w_rd_link;
    assign o_is_return    = (w_cls == CLS_JALR) & w_rs1_link & ~w_rd_link;
    assign o_dec          = {i_pc, i_instr, w_rd, w_rs1, w_cls, o_is_call, o_is_return};
endmodule

module decode_group_nw #(
    parameter int WIDTH = 2,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [WIDTH-1:0]      lane_valid_i,
    input  logic [WIDTH-1:0]      taken_branch_i,
    input  logic [WIDTH*32-1:0]   pc_i,
    input  logic [WIDTH*32-1:0]   instr_i,
    input  logic                  flush_i,
    input  logic [CNT_W-1:0]      free_slots_i,
    output logic [WIDTH-1:0]      out_valid_o,
    output logic [WIDTH*80-1:0]   out_instr_o,
    output logic [CNT_W-1:0]      out_count_o,
    output logic                  restart_o,
    output logic [31:0]           restart_pc_o,
    output logic [1:0]            restart_cause_o,
    output logic                  is_call_o,
    output logic                  is_return_o,
    output logic [31:0]           ras_pc_o
);
    localparam int DEC_W = 80;
    localparam logic [1:0] CAUSE_MISPREDICT = 2'd1;
    localparam logic [1:0] CAUSE_INVALID    = 2'd2;
    localparam logic [1:0] CAUSE_SPLIT      = 2'd3;

    logic [DEC_W-1:0] w_dec [WIDTH];
    logic [WIDTH-1:0] w_is_valid;
    logic [WIDTH-1:0] w_valid_branch;
    logic [WIDTH-1:0] w_is_call;
    logic [WIDTH-1:0] w_is_return;

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        decoder_full u_dec (
            .i_pc           (pc_i[g*32 +: 32]),
            .i_instr        (instr_i[g*32 +: 32]),
            .o_dec          (w_dec[g]),
            .o_is_valid     (w_is_valid[g]),
            .o_valid_branch (w_valid_branch[g]),
            .o_is_call      (w_is_call[g]),
            .o_is_return    (w_is_return[g])
        );
    end

    logic [DEC_W-1:0] r_buf [WIDTH];
    logic [CNT_W-1:0] r_head;
    logic [CNT_W-1:0] r_count;
    logic             r_restart;
    logic [31:0]      r_restart_pc;
    logic [1:0]       r_cause;
    logic             r_call;
    logic             r_ret;
    logic [31:0]      r_ras_pc;

    logic [CNT_W-1:0] w_keep_cnt;
    logic             w_stop;
    logic             w_restart;
    logic [31:0]      w_restart_pc;
    logic [1:0]       w_cause;
    logic             w_call;
    logic             w_ret;
    logic [31:0]      w_ras_pc;
    logic [CNT_W-1:0] w_accept;
    logic             w_capture;
    logic [WIDTH-1:0]       w_out_valid;
    logic [WIDTH*DEC_W-1:0] w_out_instr;

    // Truncation scan: kept lanes always form a prefix, so a count is enough to describe them.
    always_comb begin
        w_keep_cnt   = '0;
        w_stop       = 1'b0;
        w_restart    = 1'b0;
        w_restart_pc = 32'd0;
        w_cause      = 2'd0;
        w_call       = 1'b0;
        w_ret        = 1'b0;
        w_ras_pc     = 32'd0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_stop) begin
                w_stop = 1'b1;
            end else if (!lane_valid_i[i]) begin
                w_stop = 1'b1;
            end else if (taken_branch_i[i] & ~w_valid_branch[i] & w_is_valid[i]) begin
                w_stop       = 1'b1;
                w_restart    = 1'b1;
                w_restart_pc = pc_i[i*32 +: 32];
                w_cause      = CAUSE_MISPREDICT;
            end else if (!w_is_valid[i]) begin
                w_stop       = 1'b1;
                w_restart    = 1'b1;
                w_restart_pc = pc_i[i*32 +: 32];
                w_cause      = CAUSE_INVALID;
            end else if (w_call & (w_is_call[i] | w_is_return[i])) begin
                w_stop       = 1'b1;
                w_restart    = 1'b1;
                w_restart_pc = pc_i[i*32 +: 32];
                w_cause      = CAUSE_SPLIT;
            end else if (w_is_return[i]) begin
                w_stop     = 1'b1;
                w_ret      = 1'b1;
                w_keep_cnt = w_keep_cnt + CNT_W'(1'b1);
            end else begin
                w_keep_cnt = w_keep_cnt + CNT_W'(1'b1);
                w_ras_pc   = w_is_call[i] ? (pc_i[i*32 +: 32] + 32'd4) : w_ras_pc;
                w_call     = w_call | w_is_call[i];
                w_stop     = taken_branch_i[i] & w_valid_branch[i];
            end
        end
    end

    assign w_accept  = (free_slots_i < r_count) ? free_slots_i : r_count;
    assign ready_o   = ~rst & ~flush_i & (r_count == w_accept);
    assign w_capture = valid_i & ready_o & ~flush_i;

    // Control state: reset and flush dominate, a capture restarts at head 0, otherwise drain.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_head       <= '0;
            r_count      <= '0;
            r_restart    <= 1'b0;
            r_restart_pc <= 32'd0;
            r_cause      <= 2'd0;
            r_call       <= 1'b0;
            r_ret        <= 1'b0;
            r_ras_pc     <= 32'd0;
        end else if (w_capture) begin
            r_head       <= '0;
            r_count      <= w_keep_cnt;
            r_restart    <= w_restart;
            r_restart_pc <= w_restart_pc;
            r_cause      <= w_cause;
            r_call       <= w_call;
            r_ret        <= w_ret;
            r_ras_pc     <= w_ras_pc;
        end else begin
            r_head    <= r_head + w_accept;
            r_count   <= r_count - w_accept;
            r_restart <= 1'b0;
            r_call    <= 1'b0;
            r_ret     <= 1'b0;
        end
    end

    // Decoded lanes are payload only; validity comes from r_count, so no reset is needed.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++) begin
            if (w_capture) begin
                r_buf[i] <= w_dec[i];
            end else begin
                r_buf[i] <= r_buf[i];
            end
        end
    end

    // Compaction: slot j shows buffer lane head + j.
    always_comb begin
        w_out_valid = '0;
        w_out_instr = '0;
        for (int j = 0; j < WIDTH; j++) begin
            w_out_valid[j] = (CNT_W'(j) < r_count);
            for (int k = 0; k < WIDTH; k++) begin
                w_out_instr[j*DEC_W +: DEC_W] = w_out_instr[j*DEC_W +: DEC_W]
                    | ({DEC_W{k == (int'(r_head) + j)}} & r_buf[k]);
            end
        end
    end

    assign out_valid_o     = w_out_valid;
    assign out_instr_o     = w_out_instr;
    assign out_count_o     = r_count;
    assign restart_o       = r_restart;
    assign restart_pc_o    = r_restart_pc;
    assign restart_cause_o = r_cause;
    assign is_call_o       = r_call;
    assign is_return_o     = r_ret;
    assign ras_pc_o        = r_ras_pc;
endmodule

// File: tb/tb_decode_group_nw.sv
// Scoreboard bench for decode_group_nw (WIDTH=4): directed groups push expected slots and
// events; a negedge monitor pops them as the DUT drains slots or pulses events.

module tb_decode_group_nw;
    localparam int W = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_i;
    logic            ready_o;
    logic [W-1:0]    lane_valid_i;
    logic [W-1:0]    taken_branch_i;
    logic [W*32-1:0] pc_i;
    logic [W*32-1:0] instr_i;
    logic            flush_i;
    logic [2:0]      free_slots_i;
    logic [W-1:0]    out_valid_o;
    logic [W*80-1:0] out_instr_o;
    logic [2:0]      out_count_o;
    logic            restart_o;
    logic [31:0]     restart_pc_o;
    logic [1:0]      restart_cause_o;
    logic            is_call_o;
    logic            is_return_o;
    logic [31:0]     ras_pc_o;

    decode_group_nw #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
        .lane_valid_i(lane_valid_i), .taken_branch_i(taken_branch_i),
        .pc_i(pc_i), .instr_i(instr_i), .flush_i(flush_i), .free_slots_i(free_slots_i),
        .out_valid_o(out_valid_o), .out_instr_o(out_instr_o), .out_count_o(out_count_o),
        .restart_o(restart_o), .restart_pc_o(restart_pc_o), .restart_cause_o(restart_cause_o),
        .is_call_o(is_call_o), .is_return_o(is_return_o), .ras_pc_o(ras_pc_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [3:0]  cls;
    } slot_t;

    typedef struct {
        logic        restart;
        logic [31:0] rpc;
        logic [1:0]  cause;
        logic        call;
        logic        ret;
        logic [31:0] ras;
    } ev_t;

    slot_t exp_q[$];
    ev_t   ev_q[$];
    int    checks = 0;
    int    failures = 0;

    localparam logic [31:0] JAL_X1  = 32'h0000_00EF;
    localparam logic [31:0] RET     = 32'h0000_8067;
    localparam logic [31:0] BEQ     = 32'h0000_0063;
    localparam logic [31:0] ILLEGAL = 32'h0000_0000;

    function automatic logic [31:0] addi(input int k);
        logic [11:0] imm;
        imm = 12'(k);
        return {imm, 5'd0, 3'd0, 5'd5, 7'h13};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_slot(input logic [31:0] pc, input logic [31:0] instr,
                             input logic [4:0] rd, input logic [3:0] cls);
        slot_t s;
        s.pc = pc; s.instr = instr; s.rd = rd; s.cls = cls;
        exp_q.push_back(s);
    endtask

    task automatic push_ev(input logic restart, input logic [31:0] rpc, input logic [1:0] cause,
                           input logic call, input logic ret, input logic [31:0] ras);
        ev_t e;
        e.restart = restart; e.rpc = rpc; e.cause = cause;
        e.call = call; e.ret = ret; e.ras = ras;
        ev_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_group(input logic [31:0] base, input logic [3:0] lv, input logic [3:0] tk,
                             input logic [31:0] i0, input logic [31:0] i1,
                             input logic [31:0] i2, input logic [31:0] i3);
        lane_valid_i   = lv;
        taken_branch_i = tk;
        pc_i    = {base + 32'd12, base + 32'd8, base + 32'd4, base};
        instr_i = {i3, i2, i1, i0};
    endtask

    // Offers the current group and returns 1 time unit after the capturing edge.
    task automatic send(output int cap_cycle);
        logic got;
        got = 1'b0;
        valid_i = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            got = ready_o;
            settle();
        end
        valid_i = 1'b0;
        cap_cycle = cyc;
        if (!got) chk("capture_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: pop one expected slot per entry the issue queue takes, one event per pulse.
    always @(negedge clk) begin
        if (!rst) begin
            int n;
            n = (out_count_o < free_slots_i) ? int'(out_count_o) : int'(free_slots_i);
            for (int j = 0; j < n; j++) begin
                logic [79:0] s;
                s = out_instr_o[j*80 +: 80];
                if (exp_q.size() == 0) begin
                    chk("slot_unexpected", s[79:48], 32'hFFFF_FFFF);
                end else begin
                    slot_t e;
                    e = exp_q.pop_front();
                    chk("slot_pc", s[79:48], e.pc);
                    chk("slot_instr", s[47:16], e.instr);
                    chk("slot_rd", {27'd0, s[15:11]}, {27'd0, e.rd});
                    chk("slot_cls", {28'd0, s[5:2]}, {28'd0, e.cls});
                end
            end
            if (restart_o || is_call_o || is_return_o) begin
                if (ev_q.size() == 0) begin
                    chk("event_unexpected", {29'd0, restart_o, is_call_o, is_return_o}, 32'd0);
                end else begin
                    ev_t e;
                    e = ev_q.pop_front();
                    chk("ev_restart", {31'd0, restart_o}, {31'd0, e.restart});
                    if (e.restart) begin
                        chk("ev_restart_pc", restart_pc_o, e.rpc);
                        chk("ev_cause", {30'd0, restart_cause_o}, {30'd0, e.cause});
                    end
                    chk("ev_call", {31'd0, is_call_o}, {31'd0, e.call});
                    if (e.call) chk("ev_ras_pc", ras_pc_o, e.ras);
                    chk("ev_return", {31'd0, is_return_o}, {31'd0, e.ret});
                end
            end
        end
    end

    initial begin
        int ca, cb;
        rst = 1'b1; valid_i = 1'b0; flush_i = 1'b0; free_slots_i = 3'd4;
        set_group(32'h100, 4'b0000, 4'b0000, 32'd0, 32'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("ready_in_reset", {31'd0, ready_o}, 32'd0);
        settle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_count", {29'd0, out_count_o}, 32'd0);
        chk("rst_valid", {28'd0, out_valid_o}, 32'd0);
        chk("rst_pulses", {29'd0, restart_o, is_call_o, is_return_o}, 32'd0);
        chk("rst_ready", {31'd0, ready_o}, 32'd1);
        settle();

        // Back-to-back full groups with free_slots = 4.
        for (int i = 0; i < 4; i++) push_slot(32'h100 + 32'(4*i), addi(i + 1), 5'd5, 4'd1);
        for (int i = 0; i < 4; i++) push_slot(32'h200 + 32'(4*i), addi(i + 9), 5'd5, 4'd1);
        set_group(32'h100, 4'b1111, 4'b0000, addi(1), addi(2), addi(3), addi(4));
        send(ca);
        set_group(32'h200, 4'b1111, 4'b0000, addi(9), addi(10), addi(11), addi(12));
        send(cb);
        chk("b2b_no_gap", 32'(cb - ca), 32'd1);
        @(negedge clk);
        chk("b2b_count", {29'd0, out_count_o}, 32'd4);
        chk("b2b_valid", {28'd0, out_valid_o}, 32'hF);
        chk("b2b_ready", {31'd0, ready_o}, 32'd1);
        settle();

        // Slow drain, one slot per cycle.
        free_slots_i = 3'd1;
        for (int i = 0; i < 4; i++) push_slot(32'h300 + 32'(4*i), addi(i + 20), 5'd5, 4'd1);
        set_group(32'h300, 4'b1111, 4'b0000, addi(20), addi(21), addi(22), addi(23));
        send(ca);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("slow_count", {29'd0, out_count_o}, 32'(4 - k));
            chk("slow_ready", {31'd0, ready_o}, (k == 3) ? 32'd1 : 32'd0);
        end
        settle();
        free_slots_i = 3'd4;

        // Illegal lane 2: keep two, restart at 0x108 cause INVALID.
        push_slot(32'h100, addi(1), 5'd5, 4'd1);
        push_slot(32'h104, addi(2), 5'd5, 4'd1);
        push_ev(1'b1, 32'h108, 2'd2, 1'b0, 1'b0, 32'd0);
        set_group(32'h100, 4'b1111, 4'b0000, addi(1), addi(2), ILLEGAL, addi(4));
        send(ca);
        @(negedge clk);
        chk("inv_count", {29'd0, out_count_o}, 32'd2);
        chk("inv_restart", {31'd0, restart_o}, 32'd1);
        chk("inv_pc", restart_pc_o, 32'h108);
        chk("inv_cause", {30'd0, restart_cause_o}, 32'd2);
        @(negedge clk);
        chk("inv_pulse_once", {31'd0, restart_o}, 32'd0);
        settle();

        // Predicted-taken ADDI in lane 1: mispredict restart at 0x104.
        push_slot(32'h100, addi(1), 5'd5, 4'd1);
        push_ev(1'b1, 32'h104, 2'd1, 1'b0, 1'b0, 32'd0);
        set_group(32'h100, 4'b1111, 4'b0010, addi(1), addi(2), addi(3), addi(4));
        send(ca);
        @(negedge clk);
        chk("misp_count", {29'd0, out_count_o}, 32'd1);
        chk("misp_cause", {30'd0, restart_cause_o}, 32'd1);
        chk("misp_pc", restart_pc_o, 32'h104);
        settle();

        // Two calls: first survives, second splits the group.
        push_slot(32'h100, JAL_X1, 5'd1, 4'd5);
        push_slot(32'h104, addi(2), 5'd5, 4'd1);
        push_ev(1'b1, 32'h108, 2'd3, 1'b1, 1'b0, 32'h104);
        set_group(32'h100, 4'b1111, 4'b0000, JAL_X1, addi(2), JAL_X1, addi(4));
        send(ca);
        @(negedge clk);
        chk("split_count", {29'd0, out_count_o}, 32'd2);
        chk("split_call", {31'd0, is_call_o}, 32'd1);
        chk("split_ras", ras_pc_o, 32'h104);
        chk("split_cause", {30'd0, restart_cause_o}, 32'd3);
        settle();

        // Return in lane 1 ends the group without restart.
        push_slot(32'h100, addi(1), 5'd5, 4'd1);
        push_slot(32'h104, RET, 5'd0, 4'd6);
        push_ev(1'b0, 32'd0, 2'd0, 1'b0, 1'b1, 32'd0);
        set_group(32'h100, 4'b1111, 4'b0000, addi(1), RET, addi(3), addi(4));
        send(ca);
        @(negedge clk);
        chk("ret_count", {29'd0, out_count_o}, 32'd2);
        chk("ret_pulse", {30'd0, restart_o, is_return_o}, 32'd1);
        settle();

        // Correctly predicted taken branch in lane 1: kept, later lanes dropped.
        push_slot(32'h100, addi(1), 5'd5, 4'd1);
        push_slot(32'h104, BEQ, 5'd0, 4'd4);
        set_group(32'h100, 4'b1111, 4'b0010, addi(1), BEQ, addi(3), addi(4));
        send(ca);
        @(negedge clk);
        chk("br_count", {29'd0, out_count_o}, 32'd2);
        chk("br_no_restart", {31'd0, restart_o}, 32'd0);
        settle();

        // Lane presence counts only as a prefix from lane 0.
        push_slot(32'h100, addi(1), 5'd5, 4'd1);
        set_group(32'h100, 4'b0101, 4'b0000, addi(1), addi(2), addi(3), addi(4));
        send(ca);
        @(negedge clk);
        chk("prefix_count", {29'd0, out_count_o}, 32'd1);
        settle();

        // Flush with count 3 while a restart-producing group is offered.
        free_slots_i = 3'd0;
        for (int i = 0; i < 4; i++) push_slot(32'h400 + 32'(4*i), addi(i + 30), 5'd5, 4'd1);
        set_group(32'h400, 4'b1111, 4'b0000, addi(30), addi(31), addi(32), addi(33));
        send(ca);
        free_slots_i = 3'd1;
        settle();
        free_slots_i = 3'd0;
        flush_i = 1'b1;
        set_group(32'h500, 4'b1111, 4'b0000, ILLEGAL, addi(1), addi(2), addi(3));
        valid_i = 1'b1;
        @(negedge clk);
        chk("flush_pre_count", {29'd0, out_count_o}, 32'd3);
        chk("flush_ready", {31'd0, ready_o}, 32'd0);
        settle();
        flush_i = 1'b0;
        valid_i = 1'b0;
        @(negedge clk);
        chk("flush_count", {29'd0, out_count_o}, 32'd0);
        chk("flush_valid", {28'd0, out_valid_o}, 32'd0);
        chk("flush_pulses", {29'd0, restart_o, is_call_o, is_return_o}, 32'd0);
        chk("flush_ready_after", {31'd0, ready_o}, 32'd1);
        exp_q.delete();
        settle();
        @(negedge clk);
        chk("flush_stays_empty", {29'd0, out_count_o}, 32'd0);
        settle();

        // Reset while count is 2 and a call address is held.
        for (int i = 0; i < 4; i++)
            push_slot(32'h600 + 32'(4*i), (i == 0) ? JAL_X1 : addi(i), (i == 0) ? 5'd1 : 5'd5,
                      (i == 0) ? 4'd5 : 4'd1);
        push_ev(1'b0, 32'd0, 2'd0, 1'b1, 1'b0, 32'h604);
        set_group(32'h600, 4'b1111, 4'b0000, JAL_X1, addi(1), addi(2), addi(3));
        send(ca);
        free_slots_i = 3'd1;
        settle();
        settle();
        free_slots_i = 3'd0;
        @(negedge clk);
        chk("prerst_count", {29'd0, out_count_o}, 32'd2);
        chk("prerst_ras", ras_pc_o, 32'h604);
        settle();
        rst = 1'b1;
        settle();
        @(negedge clk);
        chk("rst2_count", {29'd0, out_count_o}, 32'd0);
        chk("rst2_valid", {28'd0, out_valid_o}, 32'd0);
        chk("rst2_pcs", restart_pc_o | ras_pc_o, 32'd0);
        chk("rst2_cause", {30'd0, restart_cause_o}, 32'd0);
        chk("rst2_pulses", {29'd0, restart_o, is_call_o, is_return_o}, 32'd0);
        chk("rst2_ready", {31'd0, ready_o}, 32'd0);
        settle();
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_ready_after", {31'd0, ready_o}, 32'd1);
        exp_q.delete();
        settle();

        chk("events_left", 32'(ev_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
